// File: rtl/slicer_pkg.sv
// Shared constants for the 4-ASK slicer: Gray symbols, FSM encoding, widths
// and an 18-bit saturation helper.
package slicer_pkg;

  localparam int DATA_W = 18;
  localparam int ACC_W  = 40;

  localparam logic [1:0] SYM_P3 = 2'b10;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_M3 = 2'b00;

  typedef enum logic {
    WAIT_REF = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam logic signed [DATA_W-1:0] DATA_MAX = 18'sh1FFFF;
  localparam logic signed [DATA_W-1:0] DATA_MIN = 18'sh20000;

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [19:0] v);
    if (v > 20'sd131071)
      return DATA_MAX;
    else if (v < -20'sd131072)
      return DATA_MIN;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/err_pwr_acc.sv
// Squared-error accumulator: sums err^2[34:17] per symbol over a window and
// publishes the saturated window average with a one-cycle valid pulse.
module err_pwr_acc
  import slicer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     sym_clk_en,
  input  logic                     clr_acc,
  input  logic signed [DATA_W-1:0] err_sample,
  output logic        [DATA_W-1:0] err_pwr,
  output logic                     pwr_valid
);

  logic signed [35:0]       prod;
  logic        [DATA_W-1:0] sq;
  logic        [ACC_W:0]    sum;
  logic        [ACC_W-1:0]  acc;
  logic        [ACC_W-1:0]  shifted;

  always_comb begin
    prod    = err_sample * err_sample;
    sq      = 18'(prod >> 17);
    sum     = {1'b0, acc} + {{(ACC_W - DATA_W + 1){1'b0}}, sq};
    shifted = acc >> WIDTH;
  end

  // clr_acc takes priority over a coincident strobe: that sample is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      err_pwr   <= '0;
      pwr_valid <= 1'b0;
    end else begin
      pwr_valid <= 1'b0;
      if (run) begin
        if (clr_acc) begin
          acc       <= '0;
          err_pwr   <= (|shifted[ACC_W-1:DATA_W]) ? '1 : shifted[DATA_W-1:0];
          pwr_valid <= 1'b1;
        end else if (sym_clk_en) begin
          acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/slicer_err.sv
// 4-ASK slicer with decision error and optional window-averaged error power
// (error power built only when SLICER_ERR_PWR_EN is defined).
//
// state    | meaning
// WAIT_REF | reference not yet settled; outputs held at 0
// RUN      | slicing on each symbol strobe, error power per window
module slicer_err
  import slicer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] dec_var,
  input  logic signed [DATA_W-1:0] ref_lvl,
  input  logic                     sym_clk_en,
  input  logic                     clr_acc,
  output logic        [1:0]        sym_out,
  output logic signed [DATA_W-1:0] err,
  output logic        [DATA_W-1:0] err_pwr,
  output logic                     pwr_valid
);

  state_t                   state;
  logic signed [19:0]       dec_x;
  logic signed [19:0]       ref_x;
  logic signed [19:0]       half_x;
  logic signed [19:0]       three_a_x;
  logic signed [19:0]       lvl_x;
  logic signed [DATA_W-1:0] three_a;
  logic        [1:0]        sym_next;
  logic signed [DATA_W-1:0] err_next;

  // Widened to 20 bits so -ref and -3a stay exact even at the range limits.
  always_comb begin
    dec_x     = {{2{dec_var[DATA_W-1]}}, dec_var};
    ref_x     = {{2{ref_lvl[DATA_W-1]}}, ref_lvl};
    half_x    = ref_x >>> 1;
    three_a   = sat_data(ref_x + half_x);
    three_a_x = {{2{three_a[DATA_W-1]}}, three_a};
    sym_next  = SYM_M3;
    lvl_x     = -three_a_x;
    if (dec_x >= ref_x) begin
      sym_next = SYM_P3;
      lvl_x    = three_a_x;
    end else if (dec_x >= 20'sd0) begin
      sym_next = SYM_P1;
      lvl_x    = half_x;
    end else if (dec_x >= -ref_x) begin
      sym_next = SYM_M1;
      lvl_x    = -half_x;
    end
    err_next = sat_data(dec_x - lvl_x);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= WAIT_REF;
      sym_out <= '0;
      err     <= '0;
    end else begin
      case (state)
        WAIT_REF: if (clr_acc) state <= RUN;
        RUN: begin
          if (sym_clk_en) begin
            sym_out <= sym_next;
            err     <= err_next;
          end
        end
        default: state <= WAIT_REF;
      endcase
    end
  end

`ifdef SLICER_ERR_PWR_EN
  err_pwr_acc #(.WIDTH(WIDTH)) u_err_pwr_acc (
    .clk        (clk),
    .reset      (reset),
    .run        (state == RUN),
    .sym_clk_en (sym_clk_en),
    .clr_acc    (clr_acc),
    .err_sample (err_next),
    .err_pwr    (err_pwr),
    .pwr_valid  (pwr_valid)
  );
`else
  assign err_pwr   = '0;
  assign pwr_valid = 1'b0;
`endif

endmodule

// File: tb/tb_slicer_err.sv
// Bench for slicer_err: directed corner cases plus random symbols checked
// against an integer model of the slicing and windowed error power.
module tb_slicer_err;

  localparam int W = 4;
`ifdef SLICER_ERR_PWR_EN
  localparam bit PWR_EN = 1'b1;
`else
  localparam bit PWR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [17:0] dec_var = '0;
  logic signed [17:0] ref_lvl = '0;
  logic               sym_clk_en = 1'b0;
  logic               clr_acc = 1'b0;
  logic        [1:0]  sym_out;
  logic signed [17:0] err;
  logic        [17:0] err_pwr;
  logic               pwr_valid;

  int n_total = 0;
  int n_bad   = 0;

  bit     m_run   = 1'b0;
  int     m_sym   = 0;
  int     m_err   = 0;
  longint m_pwr   = 0;
  int     m_valid = 0;
  longint m_sum   = 0;

  slicer_err #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .dec_var    (dec_var),
    .ref_lvl    (ref_lvl),
    .sym_clk_en (sym_clk_en),
    .clr_acc    (clr_acc),
    .sym_out    (sym_out),
    .err        (err),
    .err_pwr    (err_pwr),
    .pwr_valid  (pwr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp18(input int v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  // Four amplitude levels at +/-a and +/-3a, Gray labels 00,01,11,10.
  function automatic void slice(input int d, input int r, output int s, output int e);
    int half, a3, lvl;
    half = r >>> 1;
    a3   = clamp18(r + half);
    if (d >= r)       begin s = 2; lvl = a3;    end
    else if (d >= 0)  begin s = 3; lvl = half;  end
    else if (d >= -r) begin s = 1; lvl = -half; end
    else              begin s = 0; lvl = -a3;   end
    e = clamp18(d - lvl);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_sym = 0; m_err = 0; m_pwr = 0; m_valid = 0; m_sum = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".sym"}, sym_out, m_sym);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".pwr"}, err_pwr, PWR_EN ? m_pwr : 0);
    chk({tag, ".vld"}, pwr_valid, PWR_EN ? m_valid : 0);
  endtask

  task automatic step(input int d, input int r, input bit s, input bit c);
    int ns, ne;
    longint avg;
    dec_var    = 18'(d);
    ref_lvl    = 18'(r);
    sym_clk_en = s;
    clr_acc    = c;
    @(posedge clk);
    #1;
    m_valid = 0;
    if (!m_run) begin
      if (c) m_run = 1'b1;
    end else begin
      if (s) begin
        slice(d, r, ns, ne);
        m_sym = ns;
        m_err = ne;
      end
      if (c) begin
        avg     = m_sum / (64'sd1 << W);
        m_pwr   = (avg > 262143) ? 262143 : avg;
        m_sum   = 0;
        m_valid = 1;
      end else if (s) begin
        m_sum = m_sum + (longint'(m_err) * longint'(m_err)) / 131072;
        if (m_sum > (64'sd1 << 40) - 1) m_sum = (64'sd1 << 40) - 1;
      end
    end
    check_outputs("step");
    sym_clk_en = 1'b0;
    clr_acc    = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // strobes before the first clr_acc are ignored
    for (int i = 0; i < 6; i++) step(int'($urandom_range(0, 200000)) - 100000, 32768, 1'b1, 1'b0);
    step(40000, 32768, 1'b1, 1'b1);
    chk("wait.err0", err, 0);

    step(40000, 32768, 1'b1, 1'b0);
    chk("thr.sym", sym_out, 2);
    chk("thr.err", err, -9152);
    step(-32768, 32768, 1'b1, 1'b0);
    chk("neg.sym", sym_out, 1);
    chk("neg.err", err, -16384);
    step(0, 32768, 1'b1, 1'b0);
    chk("zero.sym", sym_out, 3);
    chk("zero.err", err, -16384);
    step(12345, 32768, 1'b0, 1'b0);
    step(-131072, 131071, 1'b1, 1'b0);
    chk("sat.sym", sym_out, 0);
    chk("sat.err", err, -1);

    // clean window of 16 equal errors
    step(0, 32768, 1'b0, 1'b1);
    step(0, 32768, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(65536, 32768, 1'b1, 1'b0);
    step(0, 32768, 1'b0, 1'b1);
    chk("win.pwr", err_pwr, PWR_EN ? 2048 : 0);
    chk("win.vld", pwr_valid, PWR_EN ? 1 : 0);
    step(0, 32768, 1'b0, 1'b0);
    chk("win.vld_drop", pwr_valid, 0);

    // collision: the large sample on the clr_acc cycle must be excluded
    for (int i = 0; i < 16; i++) step(65536, 32768, 1'b1, 1'b0);
    step(-131072, 32768, 1'b1, 1'b1);
    chk("col.pwr", err_pwr, PWR_EN ? 2048 : 0);
    chk("col.err", err, -81920);
    step(0, 32768, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = ($urandom_range(0, 9) == 0) ? 131071 : int'($urandom_range(1, 131071));
      step(int'($urandom_range(0, 262143)) - 131072, r,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    // mid-window reset
    for (int i = 0; i < 7; i++) step(65536, 32768, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("mrst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(65536, 32768, 1'b1, 1'b0);
    step(0, 32768, 1'b0, 1'b1);
    chk("mrst.first_clr", pwr_valid, 0);
    for (int i = 0; i < 16; i++) step(98304, 32768, 1'b1, 1'b0);
    step(0, 32768, 1'b0, 1'b1);
    chk("mrst.vld", pwr_valid, PWR_EN ? 1 : 0);
    step(0, 32768, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/slicer_err.md
SLICER_ERR -- requirements
Module: slicer_err

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning log2 of symbols per averaging window; must match the upstream averager's WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the system clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port dec_var, input, signed 18 bits, meaning the decision variable (1s17).
REQ-005 The block SHALL have port ref_lvl, input, signed 18 bits, meaning the average-magnitude reference (1s17) from the averager.
REQ-006 The block SHALL have port sym_clk_en, input, 1 bit, meaning the one-cycle symbol strobe.
REQ-007 The block SHALL have port clr_acc, input, 1 bit, meaning the one-cycle window-end strobe shared with the averager.
REQ-008 The block SHALL have port sym_out, output, 2 bits, meaning the Gray-coded 4-ASK symbol.
REQ-009 The block SHALL have port err, output, signed 18 bits, meaning dec_var minus the mapped level (1s17).
REQ-010 The block SHALL have port err_pwr, output, unsigned 18 bits, meaning the window-averaged squared error.
REQ-011 The block SHALL have port pwr_valid, output, 1 bit, meaning a one-cycle pulse when err_pwr updates.

Function
REQ-012 The block SHALL define constants a = ref_lvl>>>1 (half) and 3a = ref_lvl + half, computed in 19 bits and saturated to the 18-bit range.
REQ-013 Thresholds SHALL be -ref_lvl, 0 and +ref_lvl; values equal to a threshold SHALL map to the upper region.
REQ-014 Mapping SHALL be: dec>=ref -> 2'b10 / +3a; 0<=dec<ref -> 2'b11 / +a; -ref<=dec<0 -> 2'b01 / -a; dec<-ref -> 2'b00 / -3a.
REQ-015 The error SHALL be computed as dec_var - mapped in 19 bits, saturated to [-131072, 131071].
REQ-016 sym_out and err SHALL be registered on the sym_clk_en cycle, giving 1-cycle latency, and held otherwise.
REQ-017 The FSM SHALL have states WAIT_REF and RUN; reset enters WAIT_REF; the first clr_acc moves it WAIT_REF->RUN; there are no other transitions.
REQ-018 In WAIT_REF, sym_out, err, err_pwr and pwr_valid SHALL be held at 0 and strobes SHALL be ignored apart from the transition.
REQ-019 In RUN, each sym_clk_en SHALL add err^2[34:17] (36-bit product) to a 40-bit accumulator.
REQ-020 On clr_acc in RUN, err_pwr SHALL load acc>>WIDTH, saturated to 18 bits; the accumulator SHALL clear; pwr_valid SHALL pulse on the next cycle for exactly one cycle.
REQ-021 When clr_acc and sym_clk_en coincide, clr_acc SHALL win: the sample is not accumulated, but sym_out and err still update.
REQ-022 The accumulator SHALL saturate at its maximum and never wrap.

Reset
REQ-023 Reset low SHALL asynchronously force WAIT_REF, clear the accumulator, and set sym_out=0, err=0, err_pwr=0 and pwr_valid=0.
REQ-024 A reset mid-window SHALL discard the partial sum; no pwr_valid SHALL follow until a full RUN window completes.

Configuration
REQ-025 With macro SLICER_ERR_PWR_EN defined, the accumulator, err_pwr and pwr_valid SHALL be built per REQ-019..022.
REQ-026 Without SLICER_ERR_PWR_EN, no accumulator SHALL be built; err_pwr SHALL be tied to 0 and pwr_valid to 0; slicing and err SHALL be unchanged.

Structure
REQ-027 Shared package slicer_pkg SHALL hold the Gray symbol constants, the FSM state encoding, the data width (18) and the accumulator width (40).
REQ-028 One sub-module, err_pwr_acc, SHALL contain the squaring, accumulation, saturation and pwr_valid logic; it is instantiated only under SLICER_ERR_PWR_EN.

Verification
REQ-029 Threshold hit: ref_lvl=32768, in RUN, dec_var=40000 strobed -> next cycle sym_out=2'b10, err=-9152; dec_var=-32768 -> sym_out=2'b01, err=-16384.
REQ-030 Zero input: ref_lvl=32768, dec_var=0 -> sym_out=2'b11, err=-16384.
REQ-031 Saturation: ref_lvl=131071, dec_var=-131072 -> 3a saturates to 131071, sym_out=2'b00, err=-1.
REQ-032 Error power: 16 strobes each giving err=16384, then clr_acc -> err_pwr=2048 with a single-cycle pwr_valid.
REQ-033 Startup and collision: strobes before the first clr_acc -> all outputs stay 0; clr_acc coinciding with sym_clk_en -> that sample is excluded from err_pwr.
REQ-034 Reset: reset pulled low mid-window -> outputs 0 immediately; no pwr_valid until after a subsequent clr_acc plus a full window.
